// File: rtl/pe_pkg.sv
// Shared definitions for the nucleotide PE scheduler: widths, nucleotide codes,
// matrix row offsets and the controller state encoding.
package pe_pkg;
  localparam int NUCL_PER_WORD = 16;
  localparam int ROW_W         = 40;
  localparam int P_W           = 160;
  localparam int LEN_W         = 16;
  localparam int IDX_W         = 4;
  localparam int WORD_W        = 2 * NUCL_PER_WORD;
  localparam int SEL_W         = ROW_W * NUCL_PER_WORD;

  typedef enum logic [1:0] {
    NUC_A = 2'b00,
    NUC_C = 2'b01,
    NUC_G = 2'b10,
    NUC_T = 2'b11
  } nucl_e;

  // Bit offsets of each probability row inside the 160-bit matrix
  localparam int ROW_OFF_A = 120;
  localparam int ROW_OFF_C = 80;
  localparam int ROW_OFF_G = 40;
  localparam int ROW_OFF_T = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/pe_row_mux.sv
// Picks one 40-bit lane out of the PE's 640-bit selection bus; an all-A word
// never reaches the PE, so bypass substitutes matrix row A directly.
module pe_row_mux
  import pe_pkg::*;
(
  input  logic [SEL_W-1:0] pe_sel,
  input  logic [ROW_W-1:0] row_a,
  input  logic [IDX_W-1:0] idx,
  input  logic             bypass,
  output logic [ROW_W-1:0] row
);
  logic [ROW_W-1:0] lanes [NUCL_PER_WORD];

  always_comb begin
    for (int i = 0; i < NUCL_PER_WORD; i++) begin
      lanes[i] = pe_sel[i*ROW_W +: ROW_W];
    end
    row = bypass ? row_a : lanes[idx];
  end
endmodule

// File: rtl/pe_scheduler.sv
// Sequences the 16-lane nucleotide PE: loads a matrix, feeds alignment words,
// waits out the PE register stage and serialises the 16 selected rows.
module pe_scheduler
  import pe_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               p_valid,
  output logic               p_ready,
  input  logic [P_W-1:0]     p_data,
  input  logic [LEN_W-1:0]   seq_len,
  output logic               p_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  output logic [WORD_W-1:0]  pe_nucl_alig,
  output logic [P_W-1:0]     pe_matrix_P,
  output logic               pe_rst,
  input  logic [SEL_W-1:0]   pe_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [1:0]         out_nucl,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);
  state_e              state_q, state_d;
  logic [LEN_W-1:0]    words_left_q, words_left_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                bypass_q, bypass_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [P_W-1:0]      mat_q, mat_d;
  logic                p_err_q, p_err_d;
  logic [ROW_W-1:0]    mux_row;
  logic [1:0]          codes [NUCL_PER_WORD];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      idx_q        <= '0;
      bypass_q     <= 1'b0;
      word_q       <= '0;
      mat_q        <= '0;
      p_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      bypass_q     <= bypass_d;
      word_q       <= word_d;
      mat_q        <= mat_d;
      p_err_q      <= p_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    bypass_d     = bypass_q;
    word_d       = word_q;
    mat_d        = mat_q;
    p_err_d      = 1'b0;
    p_ready      = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    case (state_q)
      S_IDLE: begin
        p_ready = reset;
        if (p_valid) begin
          if ((p_data != '0) && (seq_len != '0)) begin
            mat_d        = p_data;
            words_left_d = seq_len;
            state_d      = S_FETCH;
          end else begin
            p_err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d   = in_word;
          bypass_d = (in_word == '0);
          state_d  = (in_word == '0) ? S_DRAIN : S_SETTLE;
        end
      end
      // PE registers the word during this single cycle
      S_SETTLE: state_d = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 4'hF) && (words_left_q == LEN_W'(1));
        if (out_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'hF) begin
            words_left_d = words_left_q - LEN_W'(1);
            state_d      = (words_left_q == LEN_W'(1)) ? S_IDLE : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUCL_PER_WORD; i++) begin
      codes[i] = word_q[2*i +: 2];
    end
  end

  pe_row_mux u_row_mux (
    .pe_sel (pe_sel),
    .row_a  (mat_q[ROW_OFF_A +: ROW_W]),
    .idx    (idx_q),
    .bypass (bypass_q),
    .row    (mux_row)
  );

  // Row/nucleotide outputs read as zero whenever no beat is being offered
  assign out_row      = out_valid ? mux_row : '0;
  assign out_nucl     = out_valid ? codes[idx_q] : 2'b00;
  assign out_idx      = idx_q;
  assign p_err        = p_err_q;
  assign busy         = (state_q != S_IDLE);
  assign pe_nucl_alig = word_q;
  assign pe_matrix_P  = mat_q;
  assign pe_rst       = ~reset;
endmodule

// File: tb/tb_pe_scheduler.sv
// Directed bench for pe_scheduler with a behavioural 16-lane PE (one register
// stage, holds its outputs when given an all-A word).
module tb_pe_scheduler;
  logic         clk = 1'b0;
  logic         reset;
  logic         p_valid;
  logic         p_ready;
  logic [159:0] p_data;
  logic [15:0]  seq_len;
  logic         p_err;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic [31:0]  pe_nucl_alig;
  logic [159:0] pe_matrix_P;
  logic         pe_rst;
  logic [639:0] pe_sel;
  logic         out_valid;
  logic         out_ready;
  logic [39:0]  out_row;
  logic [1:0]   out_nucl;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int lasts = 0;
  logic [159:0] cur_p;

  localparam logic [159:0] P1 = {40'h11_1111_1111, 40'h22_2222_2222,
                                 40'h33_3333_3333, 40'h44_4444_4444};
  localparam logic [159:0] P2 = {40'hA0_0000_0001, 40'hB0_0000_0002,
                                 40'hC0_0000_0003, 40'hD0_0000_0004};

  always #5 clk = ~clk;

  pe_scheduler dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_ready(p_ready),
    .p_data(p_data), .seq_len(seq_len), .p_err(p_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .pe_nucl_alig(pe_nucl_alig), .pe_matrix_P(pe_matrix_P), .pe_rst(pe_rst),
    .pe_sel(pe_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_nucl(out_nucl), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  function automatic logic [39:0] pe_row(input logic [159:0] p, input logic [1:0] c);
    case (c)
      2'd0:    return p[159:120];
      2'd1:    return p[119:80];
      2'd2:    return p[79:40];
      default: return p[39:0];
    endcase
  endfunction

  always_ff @(posedge clk or posedge pe_rst) begin
    if (pe_rst) pe_sel <= '0;
    else if (pe_nucl_alig != 32'h0)
      for (int i = 0; i < 16; i++)
        pe_sel[i*40 +: 40] <= pe_row(pe_matrix_P, pe_nucl_alig[2*i +: 2]);
  end

  task automatic load(input logic [159:0] p, input logic [15:0] len);
    checks++;
    if (p_ready !== 1'b1) begin errors++; $display("FAIL load_p_ready got %b want 1", p_ready); end
    p_valid = 1'b1; p_data = p; seq_len = len; cur_p = p;
    @(negedge clk);
    p_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
  endtask

  task automatic drain(input logic [31:0] w, input bit final_word, input bit bp);
    int idx = 0;
    int guard = 0;
    bit rdy;
    logic [39:0] exp_row;
    while (idx < 16 && guard < 400) begin
      exp_row = (w == 32'h0) ? cur_p[159:120] : pe_row(cur_p, w[2*idx +: 2]);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid idx %0d got %b want 1", idx, out_valid); end
      checks++;
      if (out_row !== exp_row) begin errors++; $display("FAIL drain_row idx %0d got %h want %h", idx, out_row, exp_row); end
      checks++;
      if (out_nucl !== w[2*idx +: 2]) begin errors++; $display("FAIL drain_nucl idx %0d got %0d want %0d", idx, out_nucl, w[2*idx +: 2]); end
      checks++;
      if (out_idx !== 4'(idx)) begin errors++; $display("FAIL drain_idx got %0d want %0d", out_idx, idx); end
      checks++;
      if (out_last !== (final_word && idx == 15)) begin errors++; $display("FAIL drain_last idx %0d got %b want %b", idx, out_last, final_word && idx == 15); end
      checks++;
      if (in_ready !== 1'b0 || p_ready !== 1'b0) begin errors++; $display("FAIL drain_readys in_ready %b p_ready %b want 0 0", in_ready, p_ready); end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rdy && out_last === 1'b1) lasts++;
      @(negedge clk);
      guard++;
      if (rdy) begin idx++; beats++; end
    end
    out_ready = 1'b0;
    checks++;
    if (idx != 16) begin errors++; $display("FAIL drain_timeout beats %0d want 16", idx); end
  endtask

  task automatic send_word(input logic [31:0] w, input bit final_word, input bit bp);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 20) begin errors++; $display("FAIL in_ready_timeout got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fetch_out_valid got %b want 0", out_valid); end
    in_valid = 1'b1; in_word = w;
    @(negedge clk);
    in_valid = 1'b0;
    if (w == 32'h0) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_latency got %b want 1", out_valid); end
    end else begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL settle_valid got %b want 0", out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", out_valid); end
    end
    drain(w, final_word, bp);
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || p_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s busy %b p_ready %b out_valid %b want 0 1 0", tag, busy, p_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (p_ready !== 1'b0 || p_err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl p_ready %b p_err %b in_ready %b out_valid %b out_last %b busy %b want all 0",
               p_ready, p_err, in_ready, out_valid, out_last, busy);
    end
    checks++;
    if (pe_nucl_alig !== 32'h0 || pe_matrix_P !== 160'h0 || out_row !== 40'h0 ||
        out_nucl !== 2'b0 || out_idx !== 4'h0) begin
      errors++;
      $display("FAIL reset_data alig %h P %h row %h nucl %0d idx %0d want 0",
               pe_nucl_alig, pe_matrix_P, out_row, out_nucl, out_idx);
    end
    checks++;
    if (pe_rst !== 1'b1) begin errors++; $display("FAIL reset_pe_rst got %b want 1", pe_rst); end
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_basic_word();
    load(P1, 16'd1);
    checks++;
    if (pe_matrix_P !== P1) begin errors++; $display("FAIL basic_matrix got %h want %h", pe_matrix_P, P1); end
    send_word(32'hE4E4_E4E4, 1'b1, 1'b0);
    check_idle("basic_done");
  endtask

  task automatic test_bypass();
    load(P1, 16'd1);
    send_word(32'h0000_0000, 1'b1, 1'b0);
    check_idle("bypass_done");
  endtask

  task automatic test_load_reject();
    p_valid = 1'b1; p_data = 160'h0; seq_len = 16'd1;
    @(negedge clk);
    checks++;
    if (p_err !== 1'b1 || p_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_p_zero p_err %b p_ready %b busy %b want 1 1 0", p_err, p_ready, busy);
    end
    p_data = P1; seq_len = 16'd0;
    @(negedge clk);
    checks++;
    if (p_err !== 1'b1 || p_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_len_zero p_err %b p_ready %b busy %b want 1 1 0", p_err, p_ready, busy);
    end
    p_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (p_err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reject_after p_err %b in_ready %b out_valid %b want 0 0 0", p_err, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    beats = 0; lasts = 0;
    load(P2, 16'd3);
    send_word(32'h1B1B_1B1B, 1'b0, 1'b1);
    send_word(32'h0000_0000, 1'b0, 1'b1);
    send_word(32'hFFFF_0055, 1'b1, 1'b1);
    checks++;
    if (beats != 48) begin errors++; $display("FAIL bp_beats got %0d want 48", beats); end
    checks++;
    if (lasts != 1) begin errors++; $display("FAIL bp_last_count got %0d want 1", lasts); end
    check_idle("bp_done");
  endtask

  task automatic test_reset_mid_drain();
    load(P1, 16'd2);
    in_valid = 1'b1; in_word = 32'hE4E4_E4E4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (7) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_idx !== 4'd7 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_idx idx %0d valid %b want 7 1", out_idx, out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pe_matrix_P !== 160'h0 || pe_nucl_alig !== 32'h0 ||
        busy !== 1'b0 || p_ready !== 1'b0 || out_row !== 40'h0) begin
      errors++;
      $display("FAIL mid_reset valid %b P %h alig %h busy %b p_ready %b row %h want 0",
               out_valid, pe_matrix_P, pe_nucl_alig, busy, p_ready, out_row);
    end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("post_reset_idle");
    end
    out_ready = 1'b0;
    load(P1, 16'd1);
    send_word(32'hE4E4_E4E4, 1'b1, 1'b0);
    check_idle("post_reset_done");
  endtask

  initial begin
    reset = 1'b0; p_valid = 1'b0; p_data = '0; seq_len = '0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b0; cur_p = '0;
    @(negedge clk);
    test_reset();
    test_basic_word();
    test_bypass();
    test_load_reject();
    test_backpressure();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time %0t limit 500000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pe_scheduler.md
# pe_scheduler

Controller that sequences the 16-lane nucleotide PE. It accepts one substitution-probability matrix per branch and a stream of 32-bit alignment words (16 nucleotides × 2 bits), drives the PE inputs, and waits out the PE register latency. It then serializes the 16 selected 40-bit probability rows onto a single valid/ready output stream for the downstream sampler. It also covers the PE's hold-on-zero behaviour: an all-A word (32'h0) is never issued to the PE.

## Interface
- NUCL_PER_WORD, 16, nucleotides per alignment word (fixed by PE)
- ROW_W, 40, probability row width
- LEN_W, 16, width of sequence word count
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- p_valid  in  1  matrix load request
- p_ready  out  1  matrix load accepted (high in IDLE only)
- p_data  in  160  rows A/C/G/T at [159:120]/[119:80]/[79:40]/[39:0]
- seq_len  in  LEN_W  number of alignment words for this matrix, sampled with p_data
- p_err  out  1  one-cycle pulse: rejected load
- in_valid / in_ready  in / out  1  alignment word handshake
- in_word  in  32  nucleotide i at [2i+1:2i]; A=00, C=01, G=10, T=11
- pe_nucl_alig  out  32  to PE
- pe_matrix_P  out  160  to PE
- pe_sel  in  640  from PE; lane i at [40i+39:40i]
- out_valid / out_ready  out / in  1  row stream handshake
- out_row  out  ROW_W  selected probability row
- out_nucl  out  2  nucleotide code for out_row
- out_idx  out  4  lane index 0..15
- out_last  out  1  high on lane 15 of the final word
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, FETCH, SETTLE, DRAIN.
- IDLE: p_ready=1. On p_valid:
  - If p_data≠0 and seq_len≠0: latch P into the pe_matrix_P register, load words_left=seq_len, go to FETCH.
  - Otherwise: consume the request, pulse p_err for 1 cycle, and stay in IDLE.
- FETCH: in_ready=1. On in_valid: latch in_word into the pe_nucl_alig register and set bypass=(in_word==0).
  - bypass=0: go to SETTLE.
  - bypass=1: go to DRAIN.
- SETTLE: exactly 1 cycle, while the PE registers the word. Then go to DRAIN.
- DRAIN: out_valid=1, starting with idx=0.
  - out_row = bypass ? P[159:120] : pe_sel[40·idx +: 40].
  - out_nucl = word[2·idx +: 2]; out_idx = idx.
  - On out_ready, idx increments.
  - On the idx=15 handshake: idx wraps to 0 and words_left decrements.
  - If words_left was 1: out_last=1 during that beat, then go to IDLE. Otherwise go to FETCH.
- The pe_nucl_alig and pe_matrix_P registers hold their values between words and after the sequence. They are never cleared except by reset, so pe_sel stays stable throughout DRAIN.
- out_valid must not drop and out_row/out_nucl/out_idx must not change while out_valid=1 and out_ready=0.
- The top level drives the PE's active-high reset with ~reset.

## Timing
- Reset values: p_ready=0 while reset is asserted, then 1 in IDLE. p_err=0, in_ready=0, out_valid=0, out_last=0, busy=0, pe_nucl_alig=0, pe_matrix_P=0, out_row=0, out_nucl=0, out_idx=0.
- Word accepted at edge E0 → PE samples it at E1 → first out_valid in the cycle after E1 (non-bypass).
- Bypass word: out_valid in the cycle after E0.
- Best-case throughput: 18 cycles/word (FETCH + SETTLE + 16 DRAIN); 17 cycles/word for bypass.
- in_ready is never high in the same cycle as out_valid. p_ready is never high while busy.
- Reset asserted mid-DRAIN: FSM returns to IDLE immediately, all outputs go to reset values, and partial output is discarded. No row is emitted after reset deasserts until a new load.
- p_valid outside IDLE is ignored (not consumed).

## Structure
- Shared package pe_pkg holds:
  - Nucleotide codes A/C/G/T.
  - ROW_W, P_W=160, NUCL_PER_WORD.
  - The FSM state enum.
  - Row-select helper constants (row offsets for A/C/G/T).
- One natural sub-module, pe_row_mux: combinational 640→40 lane select with bypass override to row A. The FSM, counters and registers stay in pe_scheduler.

## Test plan
- Load P with A=40'h11_1111_1111, C=40'h22_2222_2222, G=40'h33_3333_3333, T=40'h44_4444_4444 and seq_len=1. Send in_word=32'hE4E4_E4E4 with out_ready=1 → 16 rows in order A,C,G,T ×4 (11..,22..,33..,44..), out_idx 0..15, out_last only on idx 15; busy falls the cycle after.
- Same P, in_word=32'h0 → bypass: 16 rows of 40'h11_1111_1111, out_nucl=0; first out_valid 1 cycle after the word is accepted.
- p_data=0 or seq_len=0 → p_err pulse 1 cycle, p_ready stays 1, busy stays 0, no row emitted.
- seq_len=3 with random out_ready backpressure (~50%) → 48 beats, outputs stable while stalled, out_last exactly once (beat 48).
- Reset asserted at DRAIN idx=7 → out_valid=0 and pe_matrix_P=0 immediately. After release: IDLE, p_ready=1; a new load runs a full 16-beat word cleanly.
